mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory stage of the scalar MIPS pipeline. Consumes the EX/MEM pipeline register (ALU result, store data, control).
//  Runs loads/stores over a req/ack data-memory port and stalls the front end while an access is outstanding.
//  Drives the MEM/WB pipeline register and the MEM-stage forwarding taps used by EXE.
// PARAMETERS
//  TIMEOUT  16  max cycles waiting for mem_ack before the access is aborted (>=2)
//  CNT_W    5   width of wait counter; must hold TIMEOUT
// PORTS
//  CLK                 in   1   clock, rising edge
//  RESET               in   1   asynchronous, active-low reset
//  aluResult1_PR       in   32  EX/MEM ALU result: address for ld/st, else result
//  readDataB1_PR       in   32  EX/MEM store data
//  writeRegister1_PR   in   5   EX/MEM destination register
//  MemRead1_PR         in   1   EX/MEM load
//  MemWrite1_PR        in   1   EX/MEM store
//  MemtoReg1_PR        in   1   EX/MEM select memory data for writeback
//  do_writeback1_PR    in   1   EX/MEM writeback enable
//  mem_req             out  1   data-memory request
//  mem_we              out  1   1=write, 0=read; valid with mem_req
//  mem_addr            out  32  word address = aluResult1_PR
//  mem_wdata           out  32  = readDataB1_PR
//  mem_rdata           in   32  read data, valid with mem_ack
//  mem_ack             in   1   one-cycle completion strobe
//  FREEZE              out  1   stall IF/ID/EX and hold EX/MEM
//  mem_err             out  1   one-cycle pulse: access aborted (timeout/misalign)
//  Data1_MEM           out  32  forward tap = aluResult1_PR (combinational)
//  writeRegister1_MEM  out  5   forward tap = writeRegister1_PR
//  do_writeback1_MEM   out  1   forward tap = do_writeback1_PR & ~MemRead1_PR
//  Data1_WB            out  32  MEM/WB writeback data
//  writeRegister1_WB   out  5   MEM/WB destination
//  do_writeback1_WB    out  1   MEM/WB writeback enable
// BEHAVIOUR
//  - access = MemRead1_PR | MemWrite1_PR. MemRead&MemWrite both high: store wins.
//  - FSM IDLE/WAIT. IDLE: access -> mem_req=1 comb.; ack same cycle = 0-wait done; else -> WAIT, cnt=1.
//  - WAIT: mem_req=1, addr/wdata/we held (EX/MEM frozen); ack -> IDLE; cnt==TIMEOUT-1 w/o ack -> abort, IDLE.
//  - mem_req only in IDLE&access or WAIT; never two requests per instruction.
//  - FREEZE = access & ~done, done = mem_ack | abort (comb.). 0-wait access: no stall.
//  - MEM/WB on posedge: FREEZE=1 -> bubble (do_writeback1_WB=0; data/dest hold).
//    Else Data1_WB = MemtoReg1_PR ? (abort ? 32'h0 : mem_rdata) : aluResult1_PR; dest/enable from EX/MEM.
//  - Abort: mem_err=1 for that cycle, load writes 0, store dropped; pipeline resumes.
//  - Ack in IDLE w/o access, or a 2nd ack: ignored.
//  - Latency: loads 1+N cycles (N = ack wait); non-memory ops 1 cycle.
//  - Reset (any time, incl. WAIT): state=IDLE, cnt=0, mem_req=0, FREEZE=0, mem_err=0, *_WB=0. Outstanding access dropped.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: access with aluResult1_PR[1:0]!=0 is not issued (mem_req=0);
//    aborts in 1 cycle: mem_err pulse, no stall, load writes 0, store dropped.
//  Undefined: low address bits ignored, mem_addr={aluResult1_PR[31:2],2'b00}.
// TESTING
//  ALU op, do_wb=1, dest=5, result=0x1234 -> no req, Data1_WB=0x1234 next edge, FREEZE=0.
//  Load addr=0x100, ack same cycle, rdata=0xCAFEF00D -> no stall, Data1_WB=0xCAFEF00D, do_wb_WB=1.
//  Store addr=0x200 data=0xA5A5A5A5, ack after 3 cycles -> FREEZE=1 3 cycles, mem_we=1, do_wb_WB=0 throughout.
//  Load, no ack -> mem_req 16 cycles, mem_err pulse, Data1_WB=0, FREEZE drops.
//  RESET low in WAIT -> mem_req=0, FREEZE=0, outputs 0; after release a fresh load issues normally.
//  MEM_ALIGN_CHECK_EN on: load addr=0x102 -> mem_req never 1, mem_err pulse, Data1_WB=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the scalar MIPS pipeline.
// Issues loads and stores on a req/ack data-memory port. It freezes the
// front end while an access is outstanding, and it aborts an access that
// has waited TIMEOUT cycles without an acknowledge.
// It also drives the MEM/WB pipeline register and the MEM forwarding taps.
// Optional build macro: MEM_ALIGN_CHECK_EN. When it is defined, accesses
// to addresses that are not word aligned are never issued and abort at once.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no access outstanding; a new access is issued combinationally
// ST_WAIT | request held, EX/MEM frozen, counting cycles toward timeout
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] aluResult1_PR,
  input  logic [31:0] readDataB1_PR,
  input  logic [4:0]  writeRegister1_PR,
  input  logic        MemRead1_PR,
  input  logic        MemWrite1_PR,
  input  logic        MemtoReg1_PR,
  input  logic        do_writeback1_PR,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        FREEZE,
  output logic        mem_err,
  output logic [31:0] Data1_MEM,
  output logic [4:0]  writeRegister1_MEM,
  output logic        do_writeback1_MEM,
  output logic [31:0] Data1_WB,
  output logic [4:0]  writeRegister1_WB,
  output logic        do_writeback1_WB
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               access;
  logic               misalign;
  logic               req_int;
  logic               abort;
  logic               done;
  logic               freeze_int;

  assign access = MemRead1_PR | MemWrite1_PR;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = access & (aluResult1_PR[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Store wins when both load and store are flagged. The address is always word aligned.
  assign mem_we    = MemWrite1_PR;
  assign mem_addr  = {aluResult1_PR[31:2], 2'b00};
  assign mem_wdata = readDataB1_PR;

  // Forwarding taps. A load result is not ready yet, so a load is not forwarded.
  assign Data1_MEM          = aluResult1_PR;
  assign writeRegister1_MEM = writeRegister1_PR;
  assign do_writeback1_MEM  = do_writeback1_PR & ~MemRead1_PR;

  // State and wait-counter register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic, request and completion decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_int   = 1'b0;
    abort     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          if (misalign) begin
            abort = 1'b1;
            done  = 1'b1;
          end else begin
            req_int = 1'b1;
            if (mem_ack) begin
              done = 1'b1;
            end else begin
              state_nxt = ST_WAIT;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
      end
      ST_WAIT: begin
        req_int = 1'b1;
        if (mem_ack) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          done      = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The combinational outputs are gated by reset. This keeps them quiet while
  // reset is asserted, even if EX/MEM still presents an access.
  assign freeze_int = access & ~done;
  assign FREEZE     = RESET & freeze_int;
  assign mem_req    = RESET & req_int;
  assign mem_err    = RESET & abort;

  // MEM/WB register. A frozen cycle inserts a bubble and holds the data and destination.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Data1_WB          <= '0;
      writeRegister1_WB <= '0;
      do_writeback1_WB  <= 1'b0;
    end else if (freeze_int) begin
      do_writeback1_WB  <= 1'b0;
    end else begin
      Data1_WB          <= MemtoReg1_PR ? (abort ? 32'h0 : mem_rdata) : aluResult1_PR;
      writeRegister1_WB <= writeRegister1_PR;
      do_writeback1_WB  <= do_writeback1_PR;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed, self-checking bench for mem_stage.
// Each instruction pushes its expected MEM/WB result to a scoreboard queue.
// The result is popped and compared when the stage releases the instruction.
module tb_mem_stage;
  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] aluResult1_PR = '0;
  logic [31:0] readDataB1_PR = '0;
  logic [4:0]  writeRegister1_PR = '0;
  logic        MemRead1_PR = 1'b0;
  logic        MemWrite1_PR = 1'b0;
  logic        MemtoReg1_PR = 1'b0;
  logic        do_writeback1_PR = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        FREEZE, mem_err;
  logic [31:0] Data1_MEM;
  logic [4:0]  writeRegister1_MEM;
  logic        do_writeback1_MEM;
  logic [31:0] Data1_WB;
  logic [4:0]  writeRegister1_WB;
  logic        do_writeback1_WB;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        wb;
  } wb_t;

  wb_t sb[$];
  int  n_assert = 0;
  int  n_fail = 0;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .CLK(CLK), .RESET(RESET),
    .aluResult1_PR(aluResult1_PR), .readDataB1_PR(readDataB1_PR),
    .writeRegister1_PR(writeRegister1_PR), .MemRead1_PR(MemRead1_PR),
    .MemWrite1_PR(MemWrite1_PR), .MemtoReg1_PR(MemtoReg1_PR),
    .do_writeback1_PR(do_writeback1_PR),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .FREEZE(FREEZE), .mem_err(mem_err),
    .Data1_MEM(Data1_MEM), .writeRegister1_MEM(writeRegister1_MEM),
    .do_writeback1_MEM(do_writeback1_MEM),
    .Data1_WB(Data1_WB), .writeRegister1_WB(writeRegister1_WB),
    .do_writeback1_WB(do_writeback1_WB)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_nop();
    MemRead1_PR = 1'b0; MemWrite1_PR = 1'b0; MemtoReg1_PR = 1'b0;
    do_writeback1_PR = 1'b0; mem_ack = 1'b0;
  endtask

  // Runs one instruction from a negedge until the stage releases it.
  // ack_at < 0 means that no ack is sent. issue = 0 means that an access is
  // expected to be rejected without a request (misaligned, align check on).
  task automatic do_op(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] dest, input logic rd, input logic wr,
                       input logic m2r, input logic wb, input int ack_at,
                       input logic [31:0] rdata, input logic issue);
    logic        access;
    logic        to;
    logic        abort_exp;
    int          exp_frz, exp_req;
    int          n_req, n_frz, n_err, n_bad;
    logic        fr;
    logic        finished;
    logic [31:0] exp_addr;
    wb_t         e, got;
    access    = rd | wr;
    to        = access && issue && (ack_at < 0 || ack_at > TIMEOUT - 1);
    abort_exp = to || (access && !issue);
    exp_frz   = (!access || !issue) ? 0 : (to ? TIMEOUT - 1 : ack_at);
    exp_req   = (!access || !issue) ? 0 : exp_frz + 1;
    exp_addr  = {alu[31:2], 2'b00};
    e.data = m2r ? (abort_exp ? 32'h0 : rdata) : alu;
    e.dest = dest;
    e.wb   = wb;
    sb.push_back(e);

    aluResult1_PR = alu; readDataB1_PR = wd; writeRegister1_PR = dest;
    MemRead1_PR = rd; MemWrite1_PR = wr; MemtoReg1_PR = m2r; do_writeback1_PR = wb;
    n_req = 0; n_frz = 0; n_err = 0; n_bad = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      mem_ack   = (cyc == ack_at);
      mem_rdata = (cyc == ack_at) ? rdata : 32'hDEAD_BEEF;
      #1;
      if (cyc == 0) begin
        check({tag, "_fwd_data"}, Data1_MEM, alu);
        check({tag, "_fwd_dest"}, {27'b0, writeRegister1_MEM}, {27'b0, dest});
        check({tag, "_fwd_wb"}, {31'b0, do_writeback1_MEM}, {31'b0, wb & ~rd});
      end
      if (mem_req) begin
        n_req++;
        if (mem_addr !== exp_addr || mem_we !== wr || (wr && mem_wdata !== wd)) n_bad++;
      end
      if (FREEZE) n_frz++;
      if (mem_err) n_err++;
      fr = FREEZE;
      @(posedge CLK);
      #1;
      if (fr) check({tag, "_bubble"}, {31'b0, do_writeback1_WB}, 32'h0);
      @(negedge CLK);
      mem_ack = 1'b0;
      if (!fr) begin
        finished = 1'b1;
        break;
      end
    end
    drive_nop();
    check({tag, "_done_in_bound"}, {31'b0, finished}, 32'h1);
    check({tag, "_req_cycles"}, n_req, exp_req);
    check({tag, "_freeze_cycles"}, n_frz, exp_frz);
    check({tag, "_err_pulses"}, n_err, abort_exp ? 1 : 0);
    check({tag, "_req_fields"}, n_bad, 0);
    got = sb.pop_front();
    check({tag, "_wb_data"}, Data1_WB, got.data);
    check({tag, "_wb_dest"}, {27'b0, writeRegister1_WB}, {27'b0, got.dest});
    check({tag, "_wb_en"}, {31'b0, do_writeback1_WB}, {31'b0, got.wb});
  endtask

  initial begin
    @(negedge CLK);
    #1;
    check("rst_req", {31'b0, mem_req}, 32'h0);
    check("rst_freeze", {31'b0, FREEZE}, 32'h0);
    check("rst_err", {31'b0, mem_err}, 32'h0);
    check("rst_wb_data", Data1_WB, 32'h0);
    check("rst_wb_dest", {27'b0, writeRegister1_WB}, 32'h0);
    check("rst_wb_en", {31'b0, do_writeback1_WB}, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    do_op("alu",     32'h0000_1234, 32'h0, 5'd5,  0, 0, 0, 1, -1, 32'h0, 1);
    do_op("ld0",     32'h0000_0100, 32'h0, 5'd7,  1, 0, 1, 1,  0, 32'hCAFE_F00D, 1);
    do_op("st3",     32'h0000_0200, 32'hA5A5_A5A5, 5'd0, 0, 1, 0, 0, 3, 32'h0, 1);
    do_op("ld_to",   32'h0000_0300, 32'h0, 5'd9,  1, 0, 1, 1, -1, 32'h0, 1);
    do_op("ld_last", 32'h0000_0304, 32'h0, 5'd10, 1, 0, 1, 1, 15, 32'h1111_2222, 1);
    do_op("rdwr",    32'h0000_0408, 32'h5555_0000, 5'd3, 1, 1, 0, 0, 1, 32'h0, 1);

    // An ack with no access outstanding is ignored.
    mem_ack = 1'b1;
    #1;
    check("idle_ack_req", {31'b0, mem_req}, 32'h0);
    check("idle_ack_freeze", {31'b0, FREEZE}, 32'h0);
    check("idle_ack_err", {31'b0, mem_err}, 32'h0);
    @(negedge CLK);
    mem_ack = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
    do_op("ld_mis",  32'h0000_0102, 32'h0, 5'd11, 1, 0, 1, 1, -1, 32'h0, 0);
`else
    do_op("ld_mis",  32'h0000_0102, 32'h0, 5'd11, 1, 0, 1, 1, 2, 32'h7777_8888, 1);
`endif

    // Reset asserted while an access is waiting.
    aluResult1_PR = 32'h0000_0500; writeRegister1_PR = 5'd12;
    MemRead1_PR = 1'b1; MemtoReg1_PR = 1'b1; do_writeback1_PR = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("wait_freeze_pre", {31'b0, FREEZE}, 32'h1);
    #2;
    RESET = 1'b0;
    #1;
    check("rstw_req", {31'b0, mem_req}, 32'h0);
    check("rstw_freeze", {31'b0, FREEZE}, 32'h0);
    check("rstw_err", {31'b0, mem_err}, 32'h0);
    check("rstw_wb_data", Data1_WB, 32'h0);
    check("rstw_wb_dest", {27'b0, writeRegister1_WB}, 32'h0);
    check("rstw_wb_en", {31'b0, do_writeback1_WB}, 32'h0);
    @(negedge CLK);
    drive_nop();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    do_op("ld_post", 32'h0000_0600, 32'h0, 5'd13, 1, 0, 1, 1, 2, 32'h0BAD_F00D, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
